rram_cmd_sequencer: RTL and testbench

- Clocked controller that consumes the 4-bit latched command and its ready strobe from the command register.
- Sequences the RRAM array through read, program (SET/RESET pulses with read-verify and retry), status and soft-reset operations.
- Drives array pulse enables and masks, sense timing, and the ready/busy line back to the host interface.
- Sits between the command register / host latch logic and the RRAM array plus sense amps.

---
 rtl/rram_cmd_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_rram_cmd_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rram_cmd_sequencer.sv
// RRAM command sequencer: READ, PROGRAM (SET/RESET pulses, verify+retry under RRAM_WRITE_VERIFY_EN), READ_STATUS, SOFT_RESET.
// Latency: busy (rb_n=0) from the cycle after acceptance; while busy, every command except SOFT_RESET is dropped.
module rram_cmd_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 4,
  parameter int PULSE_CYC = 8,
  parameter int READ_CYC  = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        command,
  input  logic              cmd_ready,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] sense_data,
  output logic [ADDR_W-1:0] arr_addr,
  output logic              read_en,
  output logic [DATA_W-1:0] set_mask,
  output logic [DATA_W-1:0] reset_mask,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rb_n,
  output logic [3:0]        status
);

  localparam int CNT_MAX = (PULSE_CYC > READ_CYC + 1) ? PULSE_CYC : READ_CYC + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYC - 1);

  localparam logic [3:0] CMD_NOP  = 4'h0;
  localparam logic [3:0] CMD_READ = 4'h1;
  localparam logic [3:0] CMD_PROG = 4'h2;
  localparam logic [3:0] CMD_STAT = 4'h7;
  localparam logic [3:0] CMD_SRST = 4'hF;

  typedef enum logic [2:0] {
    IDLE, RD_SENSE, RD_DONE, PG_SET, PG_RESET, PG_VERIFY, PG_EVAL, DONE
  } state_t;

`ifdef RRAM_WRITE_VERIFY_EN
  localparam state_t PULSE_EXIT = PG_VERIFY;
  localparam logic [CNT_W-1:0] VFY_LAST   = CNT_W'(READ_CYC);
  localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRY);
`else
  localparam state_t PULSE_EXIT = DONE;
`endif

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               sync1, sync2, sync3;
  logic               acc, busy;
  logic               start_rd, start_pg, soft_rst, set_ill, clr_ill, rd_sample;
  logic [DATA_W-1:0]  wr_q, s_tgt, r_tgt;
  logic               illegal, fail;
`ifdef RRAM_WRITE_VERIFY_EN
  logic [3:0]         retry;
  logic [DATA_W-1:0]  vfy_data, s_new, r_new;
  logic               vfy_sample, retry_go, fail_set;

  assign s_new = wr_q & ~vfy_data;
  assign r_new = ~wr_q & vfy_data;
`endif

  // Acceptance is a rising edge of the synchronized strobe.
  assign acc  = sync2 & ~sync3;
  assign busy = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    start_rd  = 1'b0;
    start_pg  = 1'b0;
    soft_rst  = 1'b0;
    set_ill   = 1'b0;
    clr_ill   = 1'b0;
    rd_sample = 1'b0;
`ifdef RRAM_WRITE_VERIFY_EN
    vfy_sample = 1'b0;
    retry_go   = 1'b0;
    fail_set   = 1'b0;
`endif
    case (state)
      IDLE: state_nxt = IDLE;
      RD_SENSE: begin
        if (cnt == READ_LAST) begin
          state_nxt = RD_DONE;
          rd_sample = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      RD_DONE: state_nxt = DONE;
      PG_SET: begin
        if (cnt == PULSE_LAST) state_nxt = (r_tgt != '0) ? PG_RESET : PULSE_EXIT;
        else cnt_nxt = cnt + 1'b1;
      end
      PG_RESET: begin
        if (cnt == PULSE_LAST) state_nxt = PULSE_EXIT;
        else cnt_nxt = cnt + 1'b1;
      end
`ifdef RRAM_WRITE_VERIFY_EN
      // read_en covers the first READ_CYC cycles; the extra cycle settles the sample.
      PG_VERIFY: begin
        vfy_sample = (cnt == READ_LAST);
        if (cnt == VFY_LAST) state_nxt = PG_EVAL;
        else cnt_nxt = cnt + 1'b1;
      end
      PG_EVAL: begin
        if (vfy_data == wr_q) state_nxt = DONE;
        else if (retry != RETRY_LAST) begin
          retry_go  = 1'b1;
          state_nxt = (s_new != '0) ? PG_SET : PG_RESET;
        end else begin
          fail_set  = 1'b1;
          state_nxt = DONE;
        end
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (acc) begin
      if (command == CMD_SRST) begin
        soft_rst  = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = '0;
        rd_sample = 1'b0;
`ifdef RRAM_WRITE_VERIFY_EN
        vfy_sample = 1'b0;
        retry_go   = 1'b0;
        fail_set   = 1'b0;
`endif
      end else if (!busy) begin
        case (command)
          CMD_READ: begin
            start_rd  = 1'b1;
            state_nxt = RD_SENSE;
            cnt_nxt   = '0;
          end
          CMD_PROG: begin
            start_pg  = 1'b1;
            state_nxt = (wr_data != '0) ? PG_SET : PG_RESET;
            cnt_nxt   = '0;
          end
          CMD_STAT: clr_ill = 1'b1;
          CMD_NOP:  clr_ill = 1'b0;
          default:  set_ill = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      arr_addr <= '0;
      wr_q     <= '0;
      s_tgt    <= '0;
      r_tgt    <= '0;
      rd_data  <= '0;
      illegal  <= 1'b0;
      fail     <= 1'b0;
`ifdef RRAM_WRITE_VERIFY_EN
      retry    <= '0;
      vfy_data <= '0;
`endif
    end else begin
      sync1 <= cmd_ready;
      sync2 <= sync1;
      sync3 <= sync2;
      if (start_rd || start_pg) arr_addr <= addr_in;
      if (start_pg) begin
        wr_q  <= wr_data;
        s_tgt <= wr_data;
        r_tgt <= ~wr_data;
      end
      if (rd_sample) rd_data <= sense_data;
      if (start_rd || start_pg || soft_rst || clr_ill) illegal <= 1'b0;
      else if (set_ill) illegal <= 1'b1;
`ifdef RRAM_WRITE_VERIFY_EN
      if (vfy_sample) vfy_data <= sense_data;
      if (start_pg) retry <= '0;
      else if (retry_go) begin
        retry <= retry + 1'b1;
        s_tgt <= s_new;
        r_tgt <= r_new;
      end
      if (start_rd || start_pg || soft_rst) fail <= 1'b0;
      else if (fail_set) fail <= 1'b1;
`else
      if (start_rd || start_pg || soft_rst) fail <= 1'b0;
`endif
    end
  end

  assign set_mask   = (state == PG_SET)   ? s_tgt : '0;
  assign reset_mask = (state == PG_RESET) ? (~wr_q & r_tgt) : '0;
  assign rd_valid   = (state == RD_DONE);
  assign rb_n       = ~busy;
  assign status     = {rb_n, 1'b0, illegal, fail};
`ifdef RRAM_WRITE_VERIFY_EN
  assign read_en = (state == RD_SENSE) || ((state == PG_VERIFY) && (cnt != VFY_LAST));
`else
  assign read_en = (state == RD_SENSE);
`endif

endmodule

// File: tb/tb_rram_cmd_sequencer.sv
// Directed bench for rram_cmd_sequencer; expectations adapt to RRAM_WRITE_VERIFY_EN.
module tb_rram_cmd_sequencer;

`ifdef RRAM_WRITE_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic       clk, rst_n, cmd_ready;
  logic [3:0] command, wr_data, sense_data;
  logic [7:0] addr_in, arr_addr;
  logic       read_en, rd_valid, rb_n;
  logic [3:0] set_mask, reset_mask, rd_data, status;

  int n_cmp = 0;
  int n_err = 0;

  int busy_cyc, vld_cnt, ren_cyc, overlap, first_rst, set_tot, rst_tot;
  int set_cnt[16];
  int rst_cnt[16];
  logic [3:0] vld_data;

  rram_cmd_sequencer #(.ADDR_W(8), .DATA_W(4), .PULSE_CYC(8), .READ_CYC(4), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .cmd_ready(cmd_ready),
    .addr_in(addr_in), .wr_data(wr_data), .sense_data(sense_data),
    .arr_addr(arr_addr), .read_en(read_en), .set_mask(set_mask), .reset_mask(reset_mask),
    .rd_data(rd_data), .rd_valid(rd_valid), .rb_n(rb_n), .status(status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1);
  end

  // Raise the strobe one negedge after entry, return (strobe dropped) at the negedge of cycle A+1.
  task automatic issue(input logic [3:0] c, input logic [7:0] a, input logic [3:0] d);
    @(negedge clk);
    command = c; addr_in = a; wr_data = d; cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  // Record activity from the current negedge until rb_n returns high (bounded).
  task automatic watch();
    busy_cyc = 0; vld_cnt = 0; ren_cyc = 0; overlap = 0; first_rst = -1;
    set_tot = 0; rst_tot = 0; vld_data = '0;
    for (int k = 0; k < 16; k++) begin set_cnt[k] = 0; rst_cnt[k] = 0; end
    for (int g = 0; g < 400 && rb_n === 1'b0; g++) begin
      busy_cyc++;
      if (read_en === 1'b1) ren_cyc++;
      if (rd_valid === 1'b1) begin vld_cnt++; vld_data = rd_data; end
      if (set_mask != '0) begin set_cnt[set_mask]++; set_tot++; end
      if (reset_mask != '0) begin
        rst_cnt[reset_mask]++; rst_tot++;
        if (first_rst < 0) first_rst = busy_cyc - 1;
      end
      if (set_mask != '0 && reset_mask != '0) overlap++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cmd_ready = 1'b0; command = '0; addr_in = '0; wr_data = '0; sense_data = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({arr_addr, read_en, rd_valid} !== 10'h0) begin n_err++; $display("FAIL reset_addr_en: got %h want 000", {arr_addr, read_en, rd_valid}); end
    n_cmp++; if ({set_mask, reset_mask, rd_data} !== 12'h0) begin n_err++; $display("FAIL reset_masks_data: got %h want 000", {set_mask, reset_mask, rd_data}); end
    n_cmp++; if (rb_n !== 1'b1) begin n_err++; $display("FAIL reset_rb_n: got %b want 1", rb_n); end
    n_cmp++; if (status !== 4'b1000) begin n_err++; $display("FAIL reset_status: got %b want 1000", status); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    sense_data = 4'hA;
    @(negedge clk);
    command = 4'h1; addr_in = 8'h3C; wr_data = 4'h0; cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rb_n !== 1'b1) begin n_err++; $display("FAIL read_not_busy_at_A: got %b want 1", rb_n); end
    @(negedge clk);
    cmd_ready = 1'b0;
    n_cmp++; if ({rb_n, read_en} !== 2'b01) begin n_err++; $display("FAIL read_start: got rb_n,read_en=%b want 01", {rb_n, read_en}); end
    n_cmp++; if (arr_addr !== 8'h3C) begin n_err++; $display("FAIL read_addr: got %h want 3c", arr_addr); end
    watch();
    n_cmp++; if (busy_cyc !== 5) begin n_err++; $display("FAIL read_busy: got %0d want 5", busy_cyc); end
    n_cmp++; if (ren_cyc !== 4) begin n_err++; $display("FAIL read_en_cycles: got %0d want 4", ren_cyc); end
    n_cmp++; if (vld_cnt !== 1 || vld_data !== 4'hA) begin n_err++; $display("FAIL read_valid: got cnt=%0d data=%h want 1/a", vld_cnt, vld_data); end
    n_cmp++; if (status !== 4'b1000 || rd_data !== 4'hA) begin n_err++; $display("FAIL read_end: got status=%b rd=%h want 1000/a", status, rd_data); end
  endtask

  task automatic test_program();
    sense_data = 4'b1001;
    issue(4'h2, 8'h55, 4'b1001);
    watch();
    n_cmp++; if (set_cnt[9] !== 8 || set_tot !== 8) begin n_err++; $display("FAIL prog_set: got %0d/%0d want 8/8", set_cnt[9], set_tot); end
    n_cmp++; if (rst_cnt[6] !== 8 || rst_tot !== 8) begin n_err++; $display("FAIL prog_reset: got %0d/%0d want 8/8", rst_cnt[6], rst_tot); end
    n_cmp++; if (first_rst !== 8) begin n_err++; $display("FAIL prog_order: got first reset cycle %0d want 8", first_rst); end
    n_cmp++; if (overlap !== 0) begin n_err++; $display("FAIL prog_overlap: got %0d want 0", overlap); end
    n_cmp++; if (ren_cyc !== (VFY ? 4 : 0)) begin n_err++; $display("FAIL prog_read_en: got %0d want %0d", ren_cyc, VFY ? 4 : 0); end
    n_cmp++; if (busy_cyc !== (VFY ? 22 : 16)) begin n_err++; $display("FAIL prog_busy: got %0d want %0d", busy_cyc, VFY ? 22 : 16); end
    n_cmp++; if (status !== 4'b1000 || arr_addr !== 8'h55) begin n_err++; $display("FAIL prog_end: got status=%b addr=%h want 1000/55", status, arr_addr); end
  endtask

  task automatic test_retry();
    sense_data = 4'b0111;
    issue(4'h2, 8'h40, 4'b1111);
    watch();
    n_cmp++; if (set_cnt[15] !== 8) begin n_err++; $display("FAIL retry_first_set: got %0d want 8", set_cnt[15]); end
    n_cmp++; if (set_cnt[8] !== (VFY ? 24 : 0) || set_tot !== (VFY ? 32 : 8)) begin n_err++; $display("FAIL retry_set: got %0d/%0d want %0d/%0d", set_cnt[8], set_tot, VFY ? 24 : 0, VFY ? 32 : 8); end
    n_cmp++; if (rst_tot !== 0) begin n_err++; $display("FAIL retry_reset_skip: got %0d want 0", rst_tot); end
    n_cmp++; if (ren_cyc !== (VFY ? 16 : 0)) begin n_err++; $display("FAIL retry_read_en: got %0d want %0d", ren_cyc, VFY ? 16 : 0); end
    n_cmp++; if (busy_cyc !== (VFY ? 56 : 8)) begin n_err++; $display("FAIL retry_busy: got %0d want %0d", busy_cyc, VFY ? 56 : 8); end
    n_cmp++; if (status !== (VFY ? 4'b1001 : 4'b1000)) begin n_err++; $display("FAIL retry_status: got %b want %b", status, VFY ? 4'b1001 : 4'b1000); end
  endtask

  task automatic test_busy_drop();
    sense_data = 4'b0011;
    issue(4'h2, 8'h11, 4'b0011);
    issue(4'h1, 8'hAA, 4'h0);
    watch();
    n_cmp++; if (busy_cyc !== (VFY ? 18 : 12)) begin n_err++; $display("FAIL drop_busy_rest: got %0d want %0d", busy_cyc, VFY ? 18 : 12); end
    n_cmp++; if (vld_cnt !== 0) begin n_err++; $display("FAIL drop_no_read: got %0d want 0", vld_cnt); end
    n_cmp++; if (arr_addr !== 8'h11 || rd_data !== 4'hA) begin n_err++; $display("FAIL drop_hold: got addr=%h rd=%h want 11/a", arr_addr, rd_data); end
    n_cmp++; if (status !== 4'b1000) begin n_err++; $display("FAIL drop_status: got %b want 1000", status); end
  endtask

  task automatic test_soft_reset();
    sense_data = 4'b0011;
    issue(4'h2, 8'h22, 4'b0011);
    n_cmp++; if (set_mask !== 4'b0011) begin n_err++; $display("FAIL srst_pre_set: got %b want 0011", set_mask); end
    issue(4'hF, 8'h00, 4'h0);
    n_cmp++; if ({set_mask, reset_mask, read_en} !== 9'h0) begin n_err++; $display("FAIL srst_masks: got %h want 000", {set_mask, reset_mask, read_en}); end
    n_cmp++; if (rb_n !== 1'b1 || status !== 4'b1000) begin n_err++; $display("FAIL srst_status: got rb_n=%b status=%b want 1/1000", rb_n, status); end
    n_cmp++; if (rd_data !== 4'hA || arr_addr !== 8'h22) begin n_err++; $display("FAIL srst_hold: got rd=%h addr=%h want a/22", rd_data, arr_addr); end
    repeat (3) @(negedge clk);
    n_cmp++; if (rb_n !== 1'b1 || set_mask !== 4'h0) begin n_err++; $display("FAIL srst_stays_idle: got rb_n=%b set=%b want 1/0000", rb_n, set_mask); end
  endtask

  task automatic test_illegal();
    issue(4'h5, 8'h77, 4'h0);
    n_cmp++; if (status !== 4'b1010 || read_en !== 1'b0) begin n_err++; $display("FAIL illegal_set: got status=%b ren=%b want 1010/0", status, read_en); end
    issue(4'h0, 8'h00, 4'h0);
    n_cmp++; if (status !== 4'b1010) begin n_err++; $display("FAIL nop_keeps: got %b want 1010", status); end
    issue(4'h7, 8'h00, 4'h0);
    n_cmp++; if (status !== 4'b1000) begin n_err++; $display("FAIL status_clears: got %b want 1000", status); end
  endtask

  task automatic test_async_reset();
    logic hit;
    sense_data = 4'b1001;
    issue(4'h2, 8'h66, 4'b1001);
    hit = 1'b0;
    for (int g = 0; g < 100 && !hit; g++) begin
      hit = VFY ? (read_en === 1'b1) : (reset_mask !== 4'h0);
      if (!hit) @(negedge clk);
    end
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL arst_reach_phase: got %b want 1", hit); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({read_en, set_mask, reset_mask, rd_valid} !== 10'h0) begin n_err++; $display("FAIL arst_drive: got %h want 000", {read_en, set_mask, reset_mask, rd_valid}); end
    n_cmp++; if ({arr_addr, rd_data} !== 12'h0) begin n_err++; $display("FAIL arst_regs: got %h want 000", {arr_addr, rd_data}); end
    n_cmp++; if (rb_n !== 1'b1 || status !== 4'b1000) begin n_err++; $display("FAIL arst_status: got rb_n=%b status=%b want 1/1000", rb_n, status); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sense_data = 4'h5;
    issue(4'h1, 8'h3C, 4'h0);
    watch();
    n_cmp++; if (busy_cyc !== 5 || vld_data !== 4'h5) begin n_err++; $display("FAIL arst_resume: got busy=%0d rd=%h want 5/5", busy_cyc, vld_data); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_program();
    test_retry();
    test_busy_drop();
    test_soft_reset();
    test_illegal();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
